mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle MIPS control unit. Replaces the single-cycle decoder: FSM sequences FETCH/DECODE/EXE/MEM/WB.
//  Handshakes with variable-latency instruction and data memories; watchdog timeout, retired-instruction counter.
//  ISA: nop, addu, subu, ori, addiu, lui, lw, sw, beq, j, jal, jr; anything else is illegal.
// PARAMETERS
//  WAIT_MAX  15  max cycles FETCH/MEM waits for *_ready before bus error (1..255)
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  Op         in   6      IR[31:26]; sampled in DECODE/EXE/MEM/WB only
//  Func       in   6      IR[5:0]
//  Zero       in   1      ALU zero flag (valid in EXE)
//  imem_ready in   1      instruction word valid this cycle
//  dmem_ready in   1      data access complete this cycle
//  imem_req   out  1      instruction fetch request
//  dmem_req   out  1      data access request; MemWrite qualifies it
//  IRWr PCWr  out  1      IR load / PC load strobes
//  PCSrc      out  2      00 ALU(PC+4) 01 ALUOut(branch) 10 jump{PC[31:28],idx,00} 11 GPR[rs]
//  ALUSrcA    out  1      0 PC, 1 GPR[rs];  ALUSrcB out 2: 00 GPR[rt] 01 const 4 10 ext imm 11 ext imm<<2
//  ALUOp      out  2      00 add 01 sub 10 or 11 lui;  ExtOp out 1: 1 sign-extend, 0 zero-extend
//  MemWrite   out  1      store;  MemtoReg out 2: 00 ALUOut 01 MDR 10 PC (link)
//  RegWr      out  1      GPR write;  RegDst out 2: 00 rt 01 rd 10 $31
//  illegal    out  1      1-cycle pulse in DECODE on unknown encoding
//  bus_err    out  1      sticky, set on watchdog expiry, cleared only by reset
//  retired    out  CNT_W  instructions completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, wait_cnt=0, retired=0, bus_err=0; every strobe 0 the cycle after reset.
//  Strobes are Moore/Mealy combinational from state (+Op/Func/Zero/ready); all default 0.
//  FETCH: imem_req=1, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00. On imem_ready: IRWr=PCWr=1 -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1 (branch target to ALUOut). Then:
//    nop(all-zero Op/Func) -> FETCH, retired++.  j: PCWr,PCSrc=10 -> FETCH, retired++.
//    jal: as j plus RegWr, RegDst=10, MemtoReg=10 (PC already +4) -> FETCH, retired++.
//    jr: PCWr, PCSrc=11 -> FETCH, retired++.  illegal: pulse illegal, -> FETCH, no retire.
//    others -> EXE.
//  EXE: addu/subu: A=rs, B=rt, add/sub -> WB.  ori: B=10, ExtOp=0, or -> WB.
//    addiu: B=10, ExtOp=1, add -> WB.  lui: B=10, ALUOp=11 -> WB.
//    lw/sw: B=10, ExtOp=1, add -> MEM.  beq: A=rs, B=rt, sub; PCWr=Zero, PCSrc=01 -> FETCH, retired++.
//  MEM: dmem_req=1, MemWrite=sw. On dmem_ready: lw -> WB; sw -> FETCH, retired++.
//  WB: RegWr=1; RegDst=01 (R-type) else 00; MemtoReg=01 for lw else 00 -> FETCH, retired++.
//  Watchdog: wait_cnt clears on entering FETCH/MEM, counts each non-ready cycle there. When it reaches
//    WAIT_MAX with ready still low -> ERR: bus_err=1, all strobes 0, ERR held until reset.
//    ready on the same cycle the count hits WAIT_MAX wins (normal advance, no error).
//  Ready outside FETCH/MEM ignored. Reset in any state (incl. ERR, mid-wait) aborts with no partial strobe.
//  retired increments exactly once per completed legal instruction, on the final-state cycle.
// CONFIGURATION
//  MC_CTRL_BNE_EN defined: bne (Op 000101) decoded; EXE as beq but PCWr=!Zero; retires.
//  Not defined: Op 000101 is illegal (illegal pulse in DECODE, no PC write).
// STRUCTURE
//  Package mc_ctrl_pkg: opcode/funct localparams, state encoding (FETCH..WB, ERR), ALUOp, PCSrc,
//    ALUSrcB, MemtoReg, RegDst codes. Shared with datapath and bench.
//  Sub-module mc_ctrl_dec: combinational Op/Func -> one-hot instruction class + illegal. FSM, watchdog,
//    counter in mc_ctrl.
// TESTING
//  addu (Op 0, Func 100001), imem_ready at once -> FETCH,DECODE,EXE,WB = 4 cycles; RegWr,RegDst=01 in WB; retired=1.
//  lw with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles in MEM, MemtoReg=01 in WB, total 8 cycles.
//  beq with Zero=1 then Zero=0 -> PCWr=1/PCSrc=01 in EXE first, PCWr=0 second; both retire in 3 cycles.
//  jal -> DECODE asserts PCWr, PCSrc=10, RegWr, RegDst=10, MemtoReg=10; next state FETCH.
//  imem_ready low for WAIT_MAX=15 cycles -> bus_err=1, ERR, strobes 0; reset -> FETCH, bus_err=0, retired=0.
//  Op 000101: with MC_CTRL_BNE_EN, Zero=0 -> PCWr=1 in EXE; without, illegal pulse in DECODE, retired unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mc_ctrl_pkg
// Brief    : Opcode/funct codes, FSM state encoding, datapath mux select codes
//            and the one-hot instruction-class record for the multi-cycle
//            MIPS controller.
// Revision : 1.0
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    localparam logic [5:0] c_fn_nop   = 6'b000000;
    localparam logic [5:0] c_fn_jr    = 6'b001000;
    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_subu  = 6'b100011;

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exe    = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_err    = 3'd5;

    localparam logic [1:0] c_alu_add = 2'b00;
    localparam logic [1:0] c_alu_sub = 2'b01;
    localparam logic [1:0] c_alu_or  = 2'b10;
    localparam logic [1:0] c_alu_lui = 2'b11;

    localparam logic [1:0] c_pc_alu    = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;
    localparam logic [1:0] c_pc_rs     = 2'b11;

    localparam logic [1:0] c_srcb_rt      = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sl2 = 2'b11;

    localparam logic [1:0] c_m2r_alu = 2'b00;
    localparam logic [1:0] c_m2r_mdr = 2'b01;
    localparam logic [1:0] c_m2r_pc  = 2'b10;

    localparam logic [1:0] c_dst_rt = 2'b00;
    localparam logic [1:0] c_dst_rd = 2'b01;
    localparam logic [1:0] c_dst_ra = 2'b10;

    localparam int c_inst_w = 13;

    typedef struct packed {
        logic nop;
        logic addu;
        logic subu;
        logic ori;
        logic addiu;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
    } inst_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_dec
// Brief    : Combinational Op/Func decoder to a one-hot instruction class plus
//            an illegal flag. bne is decoded only when MC_CTRL_BNE_EN is set.
// Revision : 1.0
// ============================================================================
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]          Op,
    input  logic [5:0]          Func,
    output logic [c_inst_w-1:0] inst,
    output logic                illegal
);

    inst_t w_dec;

    always_comb begin
        w_dec = '0;
        case (Op)
            c_op_rtype: begin
                case (Func)
                    c_fn_nop:  w_dec.nop  = 1'b1;
                    c_fn_addu: w_dec.addu = 1'b1;
                    c_fn_subu: w_dec.subu = 1'b1;
                    c_fn_jr:   w_dec.jr   = 1'b1;
                    default:   w_dec.nop  = 1'b0;
                endcase
            end
            c_op_j:     w_dec.j     = 1'b1;
            c_op_jal:   w_dec.jal   = 1'b1;
            c_op_beq:   w_dec.beq   = 1'b1;
`ifdef MC_CTRL_BNE_EN
            c_op_bne:   w_dec.bne   = 1'b1;
`else
            c_op_bne:   w_dec.bne   = 1'b0;
`endif
            c_op_addiu: w_dec.addiu = 1'b1;
            c_op_ori:   w_dec.ori   = 1'b1;
            c_op_lui:   w_dec.lui   = 1'b1;
            c_op_lw:    w_dec.lw    = 1'b1;
            c_op_sw:    w_dec.sw    = 1'b1;
            default:    w_dec.nop   = 1'b0;
        endcase
    end

    assign inst    = w_dec;
    assign illegal = ~|w_dec;

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB/ERR) with
//            memory handshakes, watchdog and retired-instruction counter.
//            Define MC_CTRL_BNE_EN to add bne support.
// Revision : 1.0
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWr,
    output logic             PCWr,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             ExtOp,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic             RegWr,
    output logic [1:0]       RegDst,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0] c_wait_last = 8'(WAIT_MAX - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [7:0]          r_wait_cnt;
    logic [CNT_W-1:0]    r_retired;
    logic                r_bus_err;
    logic                w_retire;
    logic                w_waiting;
    logic                w_expire;
    logic                w_illegal;
    logic [c_inst_w-1:0] w_inst_vec;
    inst_t               w_inst;

    mc_ctrl_dec u_dec (
        .Op      (Op),
        .Func    (Func),
        .inst    (w_inst_vec),
        .illegal (w_illegal)
    );

    assign w_inst    = inst_t'(w_inst_vec);
    assign w_waiting = ((r_state == c_st_fetch) && !imem_ready) ||
                       ((r_state == c_st_mem)   && !dmem_ready);
    // The error fires on the non-ready cycle that would bring the count to WAIT_MAX.
    assign w_expire  = (r_wait_cnt == c_wait_last);

    // Everything is gated by reset so an abort never leaks a partial strobe.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        PCSrc    = c_pc_alu;
        ALUSrcA  = 1'b0;
        ALUSrcB  = c_srcb_rt;
        ALUOp    = c_alu_add;
        ExtOp    = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = c_m2r_alu;
        RegWr    = 1'b0;
        RegDst   = c_dst_rt;
        illegal  = 1'b0;
        w_next   = r_state;
        w_retire = 1'b0;
        if (!reset) begin
            case (r_state)
                c_st_fetch: begin
                    imem_req = 1'b1;
                    ALUSrcB  = c_srcb_four;
                    if (imem_ready) begin
                        IRWr   = 1'b1;
                        PCWr   = 1'b1;
                        w_next = c_st_decode;
                    end else if (w_expire) begin
                        w_next = c_st_err;
                    end
                end
                c_st_decode: begin
                    ALUSrcB = c_srcb_imm_sl2;
                    ExtOp   = 1'b1;
                    w_next  = c_st_fetch;
                    if (w_inst.nop) begin
                        w_retire = 1'b1;
                    end else if (w_inst.j || w_inst.jal) begin
                        PCWr     = 1'b1;
                        PCSrc    = c_pc_jump;
                        w_retire = 1'b1;
                        if (w_inst.jal) begin
                            RegWr    = 1'b1;
                            RegDst   = c_dst_ra;
                            MemtoReg = c_m2r_pc;
                        end
                    end else if (w_inst.jr) begin
                        PCWr     = 1'b1;
                        PCSrc    = c_pc_rs;
                        w_retire = 1'b1;
                    end else if (w_illegal) begin
                        illegal = 1'b1;
                    end else begin
                        w_next = c_st_exe;
                    end
                end
                c_st_exe: begin
                    ALUSrcA = 1'b1;
                    w_next  = c_st_wb;
                    if (w_inst.addu || w_inst.subu) begin
                        ALUSrcB = c_srcb_rt;
                        ALUOp   = w_inst.subu ? c_alu_sub : c_alu_add;
                    end else if (w_inst.ori) begin
                        ALUSrcB = c_srcb_imm;
                        ALUOp   = c_alu_or;
                    end else if (w_inst.addiu) begin
                        ALUSrcB = c_srcb_imm;
                        ExtOp   = 1'b1;
                    end else if (w_inst.lui) begin
                        ALUSrcB = c_srcb_imm;
                        ALUOp   = c_alu_lui;
                    end else if (w_inst.lw || w_inst.sw) begin
                        ALUSrcB = c_srcb_imm;
                        ExtOp   = 1'b1;
                        w_next  = c_st_mem;
                    end else if (w_inst.beq || w_inst.bne) begin
                        ALUSrcB  = c_srcb_rt;
                        ALUOp    = c_alu_sub;
                        PCSrc    = c_pc_branch;
                        PCWr     = w_inst.beq ? Zero : !Zero;
                        w_next   = c_st_fetch;
                        w_retire = 1'b1;
                    end else begin
                        w_next = c_st_fetch;
                    end
                end
                c_st_mem: begin
                    dmem_req = 1'b1;
                    MemWrite = w_inst.sw;
                    if (dmem_ready) begin
                        if (w_inst.lw) begin
                            w_next = c_st_wb;
                        end else begin
                            w_next   = c_st_fetch;
                            w_retire = 1'b1;
                        end
                    end else if (w_expire) begin
                        w_next = c_st_err;
                    end
                end
                c_st_wb: begin
                    RegWr    = 1'b1;
                    RegDst   = (w_inst.addu || w_inst.subu) ? c_dst_rd : c_dst_rt;
                    MemtoReg = w_inst.lw ? c_m2r_mdr : c_m2r_alu;
                    w_next   = c_st_fetch;
                    w_retire = 1'b1;
                end
                c_st_err: begin
                    w_next = c_st_err;
                end
                default: begin
                    w_next = c_st_fetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_fetch;
            r_wait_cnt <= 8'd0;
            r_retired  <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_next == c_st_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Brief    : Scoreboard bench for mc_ctrl: stimulus queues full expected output
//            snapshots per cycle, a negedge monitor pops and compares them.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  Op;
    logic [5:0]  Func;
    logic        Zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        IRWr;
    logic        PCWr;
    logic [1:0]  PCSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic        ExtOp;
    logic        MemWrite;
    logic [1:0]  MemtoReg;
    logic        RegWr;
    logic [1:0]  RegDst;
    logic        illegal;
    logic        bus_err;
    logic [31:0] retired;

    mc_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWr(IRWr), .PCWr(PCWr),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtOp(ExtOp), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWr(RegWr),
        .RegDst(RegDst), .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        IRWr;
        logic        PCWr;
        logic [1:0]  PCSrc;
        logic        ALUSrcA;
        logic [1:0]  ALUSrcB;
        logic [1:0]  ALUOp;
        logic        ExtOp;
        logic        MemWrite;
        logic [1:0]  MemtoReg;
        logic        RegWr;
        logic [1:0]  RegDst;
        logic        illegal;
        logic        bus_err;
        logic [31:0] retired;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ret     = 0;
    logic  berr    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        snap_t a;
        snap_t e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {imem_req, dmem_req, IRWr, PCWr, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                 ExtOp, MemWrite, MemtoReg, RegWr, RegDst, illegal, bus_err, retired};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", t, a, e);
            end
        end
    end

    function automatic snap_t base();
        snap_t e = '0;
        e.bus_err = berr;
        e.retired = 32'(ret);
        return e;
    endfunction

    task automatic step(input snap_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input string tag);
        snap_t e;
        imem_ready = 1'b1;
        e = base();
        e.imem_req = 1'b1;
        e.ALUSrcB  = 2'b01;
        e.IRWr     = 1'b1;
        e.PCWr     = 1'b1;
        step(e, tag);
    endtask

    function automatic snap_t dec_snap();
        snap_t e = base();
        e.ALUSrcB = 2'b11;
        e.ExtOp   = 1'b1;
        return e;
    endfunction

    // R-type or I-type ALU instruction: FETCH, DECODE, EXE, WB
    task automatic alu_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic [1:0] srcb, input logic [1:0] aluop,
                             input logic ext, input logic [1:0] dst, input string tag);
        snap_t e;
        Op = op; Func = fn;
        fetch_ok({tag, "_fetch"});
        step(dec_snap(), {tag, "_dec"});
        e = base(); e.ALUSrcA = 1'b1; e.ALUSrcB = srcb; e.ALUOp = aluop; e.ExtOp = ext;
        step(e, {tag, "_exe"});
        e = base(); e.RegWr = 1'b1; e.RegDst = dst;
        step(e, {tag, "_wb"});
        ret++;
    endtask

    task automatic branch_instr(input logic [5:0] op, input logic z, input logic pcwr,
                                input string tag);
        snap_t e;
        Op = op; Func = 6'b000000;
        fetch_ok({tag, "_fetch"});
        step(dec_snap(), {tag, "_dec"});
        Zero = z;
        e = base(); e.ALUSrcA = 1'b1; e.ALUOp = 2'b01; e.PCSrc = 2'b01; e.PCWr = pcwr;
        step(e, {tag, "_exe"});
        ret++;
    endtask

    task automatic decode_only(input logic [5:0] op, input logic [5:0] fn,
                               input snap_t e, input bit retires, input string tag);
        Op = op; Func = fn;
        fetch_ok({tag, "_fetch"});
        step(e, {tag, "_dec"});
        if (retires) ret++;
    endtask

    initial begin
        snap_t e;
        reset = 1'b1; Op = '0; Func = '0; Zero = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clk); #1;
        step(base(), "reset_gated");
        reset = 1'b0;

        alu_instr(6'b000000, 6'b100001, 2'b00, 2'b00, 1'b0, 2'b01, "addu");

        // lw with dmem_ready three cycles late
        Op = 6'b100011;
        fetch_ok("lw_fetch");
        step(dec_snap(), "lw_dec");
        e = base(); e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ExtOp = 1'b1;
        step(e, "lw_exe");
        e = base(); e.dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(e, "lw_mem_wait");
        dmem_ready = 1'b1;
        step(e, "lw_mem_done");
        dmem_ready = 1'b0;
        e = base(); e.RegWr = 1'b1; e.MemtoReg = 2'b01;
        step(e, "lw_wb");
        ret++;

        // sw whose data ready lands on the last allowed wait cycle
        Op = 6'b101011;
        fetch_ok("sw_fetch");
        step(dec_snap(), "sw_dec");
        e = base(); e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ExtOp = 1'b1;
        step(e, "sw_exe");
        e = base(); e.dmem_req = 1'b1; e.MemWrite = 1'b1;
        for (int i = 0; i < 14; i++) step(e, "sw_mem_wait");
        dmem_ready = 1'b1;
        step(e, "sw_mem_done");
        dmem_ready = 1'b0;
        ret++;

        branch_instr(6'b000100, 1'b1, 1'b1, "beq_taken");
        branch_instr(6'b000100, 1'b0, 1'b0, "beq_not");

        e = dec_snap(); e.PCWr = 1'b1; e.PCSrc = 2'b10; e.RegWr = 1'b1;
        e.RegDst = 2'b10; e.MemtoReg = 2'b10;
        decode_only(6'b000011, 6'b000000, e, 1'b1, "jal");
        e = dec_snap(); e.PCWr = 1'b1; e.PCSrc = 2'b10;
        decode_only(6'b000010, 6'b000000, e, 1'b1, "j");
        e = dec_snap(); e.PCWr = 1'b1; e.PCSrc = 2'b11;
        decode_only(6'b000000, 6'b001000, e, 1'b1, "jr");
        decode_only(6'b000000, 6'b000000, dec_snap(), 1'b1, "nop");

        alu_instr(6'b000000, 6'b100011, 2'b00, 2'b01, 1'b0, 2'b01, "subu");
        alu_instr(6'b001101, 6'b111111, 2'b10, 2'b10, 1'b0, 2'b00, "ori");
        alu_instr(6'b001001, 6'b000000, 2'b10, 2'b00, 1'b1, 2'b00, "addiu");
        alu_instr(6'b001111, 6'b000000, 2'b10, 2'b11, 1'b0, 2'b00, "lui");

        e = dec_snap(); e.illegal = 1'b1;
        decode_only(6'b111111, 6'b000000, e, 1'b0, "ill_op");
        decode_only(6'b000000, 6'b100000, e, 1'b0, "ill_fn");

`ifdef MC_CTRL_BNE_EN
        branch_instr(6'b000101, 1'b0, 1'b1, "bne_taken");
        branch_instr(6'b000101, 1'b1, 1'b0, "bne_not");
`else
        decode_only(6'b000101, 6'b000000, e, 1'b0, "bne_illegal");
`endif

        // fetch ready arrives on the 15th cycle: no error
        Op = 6'b000000; Func = 6'b000000;
        imem_ready = 1'b0;
        e = base(); e.imem_req = 1'b1; e.ALUSrcB = 2'b01;
        for (int i = 0; i < 14; i++) step(e, "fetch_wait");
        fetch_ok("fetch_late");
        step(dec_snap(), "fetch_late_dec");
        ret++;

        // fetch never ready: watchdog expiry
        imem_ready = 1'b0;
        e = base(); e.imem_req = 1'b1; e.ALUSrcB = 2'b01;
        for (int i = 0; i < 15; i++) step(e, "timeout_wait");
        berr = 1'b1;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(base(), "err_hold");
        dmem_ready = 1'b0;

        reset = 1'b1;
        step(base(), "err_reset_gated");
        reset = 1'b0;
        berr = 1'b0;
        ret = 0;
        imem_ready = 1'b0;
        e = base(); e.imem_req = 1'b1; e.ALUSrcB = 2'b01;
        step(e, "post_reset_fetch");
        decode_only(6'b000000, 6'b000000, dec_snap(), 1'b1, "post_reset_nop");
        imem_ready = 1'b0;
        e = base(); e.imem_req = 1'b1; e.ALUSrcB = 2'b01;
        step(e, "post_reset_count");

        @(posedge clk); #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
